// File: rtl/cdc_tx_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : cdc_tx_arbiter_if
// Purpose  : Bundle of the requester handshake, the acknowledge return path
//            and the shared data-synchronizer bus of cdc_tx_arbiter.
// Ports    : (interface signals)
//            req        [3:0]          per-requester transfer request (level)
//            req_data   [4*WIDTH-1:0]  requester i word at [i*WIDTH +: WIDTH]
//            ack_in                    acknowledge, already synchronized to CLK
//            gnt        [3:0]          one-hot, one-cycle grant pulse
//            unsync_bus [WIDTH-1:0]    registered word to the data synchronizer
//            bus_enable                registered enable to the data synchronizer
//            busy                      high whenever the arbiter is not idle
//            done                      one-cycle handshake-complete pulse
//            err                       one-cycle timeout pulse
// Modports : master -- requesters / destination side (drives req, ack_in)
//            slave  -- the arbiter itself
// Revision : 1.0  initial release
// ============================================================================
interface cdc_tx_arbiter_if #(
    parameter int WIDTH = 8
);
    logic [3:0]         req;
    logic [4*WIDTH-1:0] req_data;
    logic               ack_in;
    logic [3:0]         gnt;
    logic [WIDTH-1:0]   unsync_bus;
    logic               bus_enable;
    logic               busy;
    logic               done;
    logic               err;

    modport master (
        output req,
        output req_data,
        output ack_in,
        input  gnt,
        input  unsync_bus,
        input  bus_enable,
        input  busy,
        input  done,
        input  err
    );

    modport slave (
        input  req,
        input  req_data,
        input  ack_in,
        output gnt,
        output unsync_bus,
        output bus_enable,
        output busy,
        output done,
        output err
    );
endinterface
`default_nettype wire

// File: rtl/cdc_tx_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdc_tx_arbiter
// Purpose  : Four-way round-robin arbiter in front of one shared
//            enable-qualified data synchronizer. A granted word is placed on
//            unsync_bus one cycle before bus_enable rises, then a full
//            four-phase handshake on ack_in (high, then low) returns the
//            block to IDLE.
// Ports    : CLK  -- single clock, rising edge
//            RST  -- synchronous, active-high reset
//            bus  -- cdc_tx_arbiter_if.slave (req, req_data, ack_in in;
//                    gnt, unsync_bus, bus_enable, busy, done, err out)
// Params   : WIDTH   -- word width of each requester and of unsync_bus
//            TIMEOUT -- handshake timeout in CLK cycles (1..255), only used
//                       when the timeout feature is compiled in
// Macro    : CDC_ARB_TIMEOUT_EN -- when defined, each wait state gives up
//            after TIMEOUT cycles and pulses err; when undefined the wait
//            states wait forever and err is constant 0.
// Revision : 1.0  initial release
// ============================================================================
module cdc_tx_arbiter #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 255
) (
    input  wire logic       CLK,
    input  wire logic       RST,
    cdc_tx_arbiter_if.slave bus
);

    // Out-of-range TIMEOUT would silently truncate into the 8-bit counter.
    generate
        if ((TIMEOUT < 1) || (TIMEOUT > 255)) begin : g_timeout_range_check
            $error("cdc_tx_arbiter: TIMEOUT must lie in 1..255");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETUP   = 2'd1,
        WAIT_HI = 2'd2,
        WAIT_LO = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_gnt;
    logic [3:0]       w_gnt_nxt;
    logic [WIDTH-1:0] r_bus;
    logic [WIDTH-1:0] w_bus_nxt;
    logic             r_en;
    logic             w_en_nxt;
    logic             r_done;
    logic             w_done_nxt;
    logic             r_err;
    logic             w_err_nxt;
    logic [1:0]       r_last;
    logic [1:0]       w_last_nxt;

    logic             w_win_vld;
    logic [1:0]       w_win_idx;
    logic             w_tmo;

    // ------------------------------------------------------------------------
    // Round-robin pick: scan last+1, last+2, last+3, last (mod 4). The
    // previously granted requester is therefore always considered last.
    // ------------------------------------------------------------------------
    always_comb begin
        w_win_vld = 1'b0;
        w_win_idx = r_last;
        for (int k = 1; k <= 4; k++) begin
            if (!w_win_vld && bus.req[r_last + 2'(k)]) begin
                w_win_vld = 1'b1;
                w_win_idx = r_last + 2'(k);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Handshake timeout. The counter restarts whenever a wait state is
    // entered (including WAIT_HI -> WAIT_LO) and counts every cycle spent
    // waiting; w_tmo fires on the edge at which the count reaches TIMEOUT,
    // i.e. after exactly TIMEOUT cycles in the current wait state.
    // ------------------------------------------------------------------------
`ifdef CDC_ARB_TIMEOUT_EN
    localparam logic [7:0] c_TIMEOUT = 8'(TIMEOUT);

    logic [7:0] r_cnt;
    logic       w_in_wait;
    logic       w_wait_entry;

    assign w_in_wait    = (r_state == WAIT_HI) || (r_state == WAIT_LO);
    assign w_tmo        = w_in_wait && ((r_cnt + 8'd1) == c_TIMEOUT);
    assign w_wait_entry = (w_state_nxt != r_state) &&
                          ((w_state_nxt == WAIT_HI) || (w_state_nxt == WAIT_LO));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_cnt <= 8'd0;
        end else if (w_wait_entry || !w_in_wait) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end
`else
    // No counter: the wait states only leave on the ack_in level.
    assign w_tmo = 1'b0;
`endif

    // ------------------------------------------------------------------------
    // State register and all registered outputs.
    // ------------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_gnt   <= 4'b0000;
            r_bus   <= '0;
            r_en    <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_last  <= 2'd3;   // requester 0 wins first after reset
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_bus   <= w_bus_nxt;
            r_en    <= w_en_nxt;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_last  <= w_last_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Next-state and next-output decode. gnt, done and err are pulses and
    // default low; unsync_bus, bus_enable and last-granted default to hold.
    // req is only looked at in IDLE and ack_in only in the two wait states.
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = 4'b0000;
        w_bus_nxt   = r_bus;
        w_en_nxt    = r_en;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        w_last_nxt  = r_last;

        case (r_state)
            IDLE: begin
                if (w_win_vld) begin
                    w_state_nxt = SETUP;
                    w_gnt_nxt   = 4'b0001 << w_win_idx;
                    w_bus_nxt   = bus.req_data[int'(w_win_idx) * WIDTH +: WIDTH];
                    w_last_nxt  = w_win_idx;
                end
            end

            // Data has been stable for one cycle; now qualify it.
            SETUP: begin
                w_state_nxt = WAIT_HI;
                w_en_nxt    = 1'b1;
            end

            WAIT_HI: begin
                if (bus.ack_in) begin
                    w_state_nxt = WAIT_LO;
                    w_en_nxt    = 1'b0;
                end else if (w_tmo) begin
                    w_state_nxt = WAIT_LO;
                    w_en_nxt    = 1'b0;
                    w_err_nxt   = 1'b1;
                end
            end

            WAIT_LO: begin
                if (!bus.ack_in) begin
                    w_state_nxt = IDLE;
                    w_done_nxt  = 1'b1;
                end else if (w_tmo) begin
                    w_state_nxt = IDLE;
                    w_err_nxt   = 1'b1;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_en_nxt    = 1'b0;
            end
        endcase
    end

    assign bus.gnt        = r_gnt;
    assign bus.unsync_bus = r_bus;
    assign bus.bus_enable = r_en;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = r_done;
    assign bus.err        = r_err;

endmodule
`default_nettype wire

// File: tb/tb_cdc_tx_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_cdc_tx_arbiter
// Purpose  : Self-checking bench for cdc_tx_arbiter. A transaction-level
//            model predicts every output each cycle; directed scenarios add
//            hand-computed literal expectations.
// Revision : 1.0  initial release
// ============================================================================
module tb_cdc_tx_arbiter;

    localparam int WIDTH = 8;
`ifdef CDC_ARB_TIMEOUT_EN
    localparam int TMO    = 10;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int TMO    = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    localparam int EN_HI = 0;
    localparam int EN_LO = 1;
    localparam int DONE  = 2;
    localparam int ERR   = 3;

    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    cdc_tx_arbiter_if #(.WIDTH(WIDTH)) bus ();

    cdc_tx_arbiter #(.WIDTH(WIDTH), .TIMEOUT(TMO)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic expire(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ------------------------------------------------------------------------
    // Model: a transfer is "active" from grant to return-to-idle; the first
    // cycle after the grant is a data-settle cycle, then the word is enabled
    // until ack is seen high, then we wait for ack low.
    // ------------------------------------------------------------------------
    function automatic int pick_rr(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++)
            if (r[(last + k) % 4]) return (last + k) % 4;
        return -1;
    endfunction

    int               m_last, m_wait, m_win;
    bit               m_active, m_fresh, m_acked;
    logic [3:0]       e_gnt;
    logic [WIDTH-1:0] e_bus;
    logic             e_en, e_done, e_err;

    always @(posedge CLK) begin
        if (RST) begin
            m_active = 0; m_fresh = 0; m_acked = 0; m_wait = 0; m_last = 3;
            e_gnt = '0; e_bus = '0; e_en = 0; e_done = 0; e_err = 0;
        end else begin
            e_gnt = '0; e_done = 0; e_err = 0;
            if (!m_active) begin
                if (bus.req != 4'b0000) begin
                    m_win    = pick_rr(bus.req, m_last);
                    e_gnt    = 4'(1 << m_win);
                    e_bus    = bus.req_data[m_win*WIDTH +: WIDTH];
                    m_last   = m_win;
                    m_active = 1; m_fresh = 1; m_acked = 0;
                end
            end else if (m_fresh) begin
                m_fresh = 0; e_en = 1; m_wait = 0;
            end else if (!m_acked) begin
                if (bus.ack_in) begin
                    e_en = 0; m_acked = 1; m_wait = 0;
                end else begin
                    m_wait++;
                    if (TMO_EN && m_wait == TMO) begin
                        e_en = 0; e_err = 1; m_acked = 1; m_wait = 0;
                    end
                end
            end else begin
                if (!bus.ack_in) begin
                    m_active = 0; e_done = 1;
                end else begin
                    m_wait++;
                    if (TMO_EN && m_wait == TMO) begin
                        m_active = 0; e_err = 1;
                    end
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (cmp_en) begin
            chk("gnt",        32'(bus.gnt),        32'(e_gnt));
            chk("unsync_bus", 32'(bus.unsync_bus), 32'(e_bus));
            chk("bus_enable", 32'(bus.bus_enable), 32'(e_en));
            chk("busy",       32'(bus.busy),       32'(m_active));
            chk("done",       32'(bus.done),       32'(e_done));
            chk("err",        32'(bus.err),        32'(e_err));
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers (inputs change on the falling edge only)
    // ------------------------------------------------------------------------
    function automatic logic probe(input int which);
        case (which)
            EN_HI:   return bus.bus_enable;
            EN_LO:   return !bus.bus_enable;
            DONE:    return bus.done;
            default: return bus.err;
        endcase
    endfunction

    task automatic wait_for(input int which, input string name);
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (probe(which)) return;
        end
        expire(name);
    endtask

    task automatic wait_gnt(output logic [3:0] g);
        g = 4'b0000;
        for (int k = 0; k < 20; k++) begin
            @(negedge CLK);
            if (bus.gnt != 4'b0000) begin
                g = bus.gnt;
                return;
            end
        end
        expire("wait_gnt");
    endtask

    // ack rises 2 cycles after enable is seen, falls 2 cycles after it drops
    task automatic handshake();
        wait_for(EN_HI, "hs_en_hi");
        repeat (2) @(negedge CLK);
        bus.ack_in = 1'b1;
        wait_for(EN_LO, "hs_en_lo");
        repeat (2) @(negedge CLK);
        bus.ack_in = 1'b0;
        wait_for(DONE, "hs_done");
    endtask

    task automatic pulse_reset();
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
    endtask

    logic [3:0] g;
    logic [3:0] order [5];
    int         hi_cnt;

    initial begin
        bus.req      = 4'b0000;
        bus.ack_in   = 1'b0;
        bus.req_data = {8'h3C, 8'hA5, 8'h5A, 8'hC3};  // words 3,2,1,0

        // Reset state
        repeat (3) @(negedge CLK);
        chk("rst_gnt",  32'(bus.gnt),        32'h0);
        chk("rst_bus",  32'(bus.unsync_bus), 32'h0);
        chk("rst_en",   32'(bus.bus_enable), 32'h0);
        chk("rst_busy", 32'(bus.busy),       32'h0);
        chk("rst_done", 32'(bus.done),       32'h0);
        chk("rst_err",  32'(bus.err),        32'h0);
        cmp_en = 1'b1;
        RST    = 1'b0;

        // Single transfer from requester 2
        bus.req = 4'b0100;
        wait_gnt(g);
        chk("t1_gnt", 32'(g),              32'h4);
        chk("t1_bus", 32'(bus.unsync_bus), 32'hA5);
        chk("t1_en0", 32'(bus.bus_enable), 32'h0);
        bus.req = 4'b0000;
        @(negedge CLK);
        chk("t1_en1", 32'(bus.bus_enable), 32'h1);
        chk("t1_gnt_pulse", 32'(bus.gnt),  32'h0);
        repeat (2) @(negedge CLK);
        bus.ack_in = 1'b1;
        wait_for(EN_LO, "t1_en_lo");
        repeat (2) @(negedge CLK);
        bus.ack_in = 1'b0;
        wait_for(DONE, "t1_done");
        chk("t1_busy", 32'(bus.busy), 32'h0);
        @(negedge CLK);
        chk("t1_busy_after", 32'(bus.busy),       32'h0);
        chk("t1_bus_hold",   32'(bus.unsync_bus), 32'hA5);

        // Round-robin with all requesters asserted
        pulse_reset();
        bus.req = 4'b1111;
        for (int t = 0; t < 5; t++) begin
            wait_gnt(order[t]);
            handshake();
            if (t == 4) bus.req = 4'b0000;
        end
        chk("rr_0", 32'(order[0]), 32'h1);
        chk("rr_1", 32'(order[1]), 32'h2);
        chk("rr_2", 32'(order[2]), 32'h4);
        chk("rr_3", 32'(order[3]), 32'h8);
        chk("rr_4", 32'(order[4]), 32'h1);

        // Request raised mid-transfer waits for IDLE
        pulse_reset();
        bus.req = 4'b0001;
        wait_gnt(g);
        chk("t3_gnt0", 32'(g), 32'h1);
        bus.req = 4'b0000;
        wait_for(EN_HI, "t3_en_hi");
        bus.req = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            chk("t3_no_gnt", 32'(bus.gnt),        32'h0);
            chk("t3_bus_w0", 32'(bus.unsync_bus), 32'hC3);
        end
        bus.ack_in = 1'b1;
        wait_for(EN_LO, "t3_en_lo");
        bus.ack_in = 1'b0;
        wait_for(DONE, "t3_done");
        chk("t3_bus_at_done", 32'(bus.unsync_bus), 32'hC3);
        @(negedge CLK);
        chk("t3_gnt1", 32'(bus.gnt),        32'h2);
        chk("t3_bus1", 32'(bus.unsync_bus), 32'h5A);
        bus.req = 4'b0000;
        handshake();

        // Reset in WAIT_HI aborts and restores requester-0 priority
        bus.req = 4'b0100;
        wait_gnt(g);
        chk("t4_gnt2", 32'(g), 32'h4);
        bus.req = 4'b0000;
        wait_for(EN_HI, "t4_en_hi");
        RST = 1'b1;
        @(negedge CLK);
        chk("t4_en",   32'(bus.bus_enable), 32'h0);
        chk("t4_busy", 32'(bus.busy),       32'h0);
        chk("t4_done", 32'(bus.done),       32'h0);
        chk("t4_err",  32'(bus.err),        32'h0);
        RST     = 1'b0;
        bus.req = 4'b1111;
        wait_gnt(g);
        chk("t4_first_after_rst", 32'(g), 32'h1);
        bus.req = 4'b0000;
        handshake();

        // Minimum-length transfer; ack high in IDLE/SETUP is ignored
        bus.ack_in = 1'b1;
        bus.req    = 4'b1000;
        wait_gnt(g);
        chk("t5_gnt3", 32'(g), 32'h8);
        bus.req = 4'b1001;
        @(negedge CLK);
        chk("t5_en_despite_ack", 32'(bus.bus_enable), 32'h1);
        @(negedge CLK);
        chk("t5_en_drop", 32'(bus.bus_enable), 32'h0);
        bus.ack_in = 1'b0;
        @(negedge CLK);
        chk("t5_done", 32'(bus.done), 32'h1);
        @(negedge CLK);
        chk("t5_gnt_spacing4", 32'(bus.gnt), 32'h1);
        bus.req = 4'b0000;
        handshake();

        // ack never arrives
        bus.req = 4'b0010;
        wait_gnt(g);
        chk("t6_gnt1", 32'(g), 32'h2);
        bus.req = 4'b0000;
        wait_for(EN_HI, "t6_en_hi");
`ifdef CDC_ARB_TIMEOUT_EN
        hi_cnt = 1;
        for (int k = 0; k < 300; k++) begin
            @(negedge CLK);
            if (!bus.bus_enable) break;
            hi_cnt++;
        end
        chk("t6_en_cycles", 32'(hi_cnt),  32'(TMO));
        chk("t6_err_pulse", 32'(bus.err), 32'h1);
        @(negedge CLK);
        chk("t6_err_single", 32'(bus.err), 32'h0);
        repeat (2) @(negedge CLK);
        chk("t6_idle", 32'(bus.busy), 32'h0);
`else
        hi_cnt = 0;
        repeat (1000) begin
            @(negedge CLK);
            if (bus.bus_enable && !bus.err) hi_cnt++;
        end
        chk("t6_en_cycles", 32'(hi_cnt),         32'd1000);
        chk("t6_en_held",   32'(bus.bus_enable), 32'h1);
        chk("t6_busy_held", 32'(bus.busy),       32'h1);
        bus.ack_in = 1'b1;
        wait_for(EN_LO, "t6_en_lo");
        bus.ack_in = 1'b0;
        wait_for(DONE, "t6_done");
`endif

        repeat (3) @(negedge CLK);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
